imem_load_fetch_ctrl: RTL and testbench

//  Sequencer for the 64x16 shift-loaded instruction memory (IMEM).
//  - LOAD: accepts a program word stream from the host and drives the IMEM shift port.
//  - RUN: walks a program counter, converts PC to the IMEM address and hands instructions to the core.

---
 rtl/imem_pkg.sv | 7 +
 rtl/imem_load_fetch_ctrl.sv | 114 +++++++++++
 tb/tb_imem_load_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared IMEM geometry and controller state encoding
package imem_pkg;
    localparam int IMEM_DEPTH = 64;
    localparam int IMEM_WIDTH = 16;
    localparam int IMEM_AW    = 6;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/imem_load_fetch_ctrl.sv
// imem_load_fetch_ctrl: loads a host word stream into the shift IMEM, then fetches it to the core
module imem_load_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int WIDTH = IMEM_WIDTH,
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             run_start,
    input  logic             abort,
    input  logic             jump_valid,
    input  logic [AW-1:0]    jump_target,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr_data,
    output logic [AW-1:0]    instr_pc,
    output logic             done,
    output logic             overflow,
    output logic [AW:0]      prog_len,
    output logic             imem_shift_enable,
    output logic [WIDTH-1:0] imem_new_value,
    output logic [AW-1:0]    imem_addr,
    input  logic [WIDTH-1:0] imem_data_out
);
    state_t      state, state_n;
    logic [AW:0] count, count_n, pc, pc_n, jump_pc;
    logic        overflow_n;

    assign jump_pc    = {1'b0, jump_target};
    assign instr_data = imem_data_out;
    assign instr_pc   = pc[AW-1:0];
    assign prog_len   = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            pc       <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            pc       <= pc_n;
            overflow <= overflow_n;
        end
    end

    always_comb begin
        state_n           = state;
        count_n           = count;
        pc_n              = pc;
        overflow_n        = overflow;
        in_ready          = 1'b0;
        instr_valid       = 1'b0;
        done              = 1'b0;
        imem_shift_enable = 1'b0;
        imem_new_value    = '0;
        imem_addr         = '0;
        if (abort) begin
            state_n = IDLE;
            pc_n    = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load_start) begin
                        state_n    = LOAD;
                        count_n    = '0;
                        overflow_n = 1'b0;
                    end else if (run_start) begin
                        pc_n    = '0;
                        done    = (count == '0);
                        state_n = done ? DONE : RUN;
                    end
                end
                LOAD: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        imem_shift_enable = 1'b1;
                        imem_new_value    = in_data;
                        // a full IMEM still shifts; the oldest word falls off the far end
                        if (count == (AW+1)'(DEPTH)) overflow_n = 1'b1;
                        else count_n = count + 1'b1;
                        if (in_last) state_n = IDLE;
                    end
                end
                RUN: begin
                    // newest word sits at address 0, so the oldest retained word is at count-1
                    imem_addr = AW'(count - pc - (AW+1)'(1));
                    if (pc >= count) begin
                        state_n = DONE;
                        done    = 1'b1;
                    end else begin
                        instr_valid = 1'b1;
                        if (jump_valid) begin
                            pc_n    = jump_pc;
                            done    = (jump_pc >= count);
                            state_n = done ? DONE : RUN;
                        end else if (instr_ready) begin
                            pc_n = pc + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// tb_imem_load_fetch_ctrl: directed bench with a shift-IMEM model and an expected-instruction scoreboard
module tb_imem_load_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst, load_start, in_valid, in_last, run_start, abort, jump_valid, instr_ready;
    logic [15:0] in_data;
    logic [5:0]  jump_target;
    logic        in_ready, instr_valid, done, overflow, imem_shift_enable;
    logic [15:0] instr_data, imem_new_value, imem_data_out;
    logic [5:0]  instr_pc, imem_addr;
    logic [6:0]  prog_len;
    logic [15:0] mem [64];
    int          errors = 0;
    int          checks = 0;

    typedef struct {logic [15:0] d; logic [5:0] pc; logic [5:0] a;} exp_t;
    exp_t        sb[$];
    logic [15:0] prog[$];

    always #5 clk = ~clk;

    imem_load_fetch_ctrl dut (
        .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .run_start(run_start), .abort(abort),
        .jump_valid(jump_valid), .jump_target(jump_target), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc), .done(done),
        .overflow(overflow), .prog_len(prog_len), .imem_shift_enable(imem_shift_enable),
        .imem_new_value(imem_new_value), .imem_addr(imem_addr), .imem_data_out(imem_data_out)
    );

    // shift IMEM: new word enters at address 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (imem_shift_enable) begin
            for (int i = 63; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= imem_new_value;
        end
    end
    assign imem_data_out = mem[imem_addr];

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] base, input int n);
        prog.delete();
        load_start = 1'b1;
        next();
        load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 16'(i);
            in_last  = (i == n - 1);
            #2;
            chk("in_ready", in_ready, 1);
            chk("shift_en", imem_shift_enable, 1);
            chk("new_value", imem_new_value, in_data);
            prog.push_back(in_data);
            if (prog.size() > 64) void'(prog.pop_front());
            next();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run(input int stall_pc, input int stall_n);
        int n     = prog.size();
        int guard = 0;
        int stall = stall_n;
        sb.delete();
        for (int i = 0; i < n; i++) sb.push_back('{prog[i], 6'(i), 6'(n - 1 - i)});
        run_start = 1'b1;
        next();
        run_start = 1'b0;
        while (sb.size() > 0 && guard < 300) begin
            instr_ready = !(int'(sb[0].pc) == stall_pc && stall > 0);
            #2;
            chk("instr_valid", instr_valid, 1);
            chk("instr_data", instr_data, sb[0].d);
            chk("instr_pc", instr_pc, sb[0].pc);
            chk("imem_addr", imem_addr, sb[0].a);
            if (instr_ready) void'(sb.pop_front());
            else stall--;
            guard++;
            next();
        end
        chk("run_pending", sb.size(), 0);
        instr_ready = 1'b1;
        #2;
        chk("done", done, 1);
        chk("valid_at_end", instr_valid, 0);
        chk("prog_len_run", prog_len, n);
        next();
        #2;
        chk("done_pulse", done, 0);
    endtask

    initial begin
        rst = 1'b1; load_start = 0; in_valid = 0; in_last = 0; in_data = '0; run_start = 0;
        abort = 0; jump_valid = 0; jump_target = '0; instr_ready = 0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_shift", imem_shift_enable, 0);
        next();
        rst = 1'b0;
        next();

        // basic load and run, then the same program with backpressure at pc 1
        load(16'hA001, 3);
        chk("prog_len3", prog_len, 3);
        run(-1, 0);
        run(1, 4);

        // overflow: 66 words into a 64-word IMEM
        load(16'h0000, 66);
        #2;
        chk("overflow", overflow, 1);
        chk("prog_len64", prog_len, 64);
        run(-1, 0);

        // reset in the middle of a load
        load_start = 1'b1;
        next();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hD000 + 16'(i);
            next();
        end
        in_data = 16'hD002;
        rst     = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_shift", imem_shift_enable, 0);
        chk("mid_rst_new_value", imem_new_value, 0);
        chk("mid_rst_prog_len", prog_len, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_pc", instr_pc, 0);
        chk("mid_rst_data", instr_data, 0);
        in_valid = 1'b0;
        prog.delete();
        next();
        rst = 1'b0;
        next();

        // run with an empty program finishes at once
        run_start = 1'b1;
        #2;
        chk("empty_done", done, 1);
        next();
        run_start = 1'b0;
        #2;
        chk("empty_done_pulse", done, 0);
        chk("empty_valid", instr_valid, 0);

        // jump wins over handshake; out-of-range jump ends the run
        load(16'hC001, 3);
        run_start = 1'b1;
        next();
        run_start   = 1'b0;
        instr_ready = 1'b1;
        #2;
        chk("jump_pc0", instr_pc, 0);
        next();
        jump_valid  = 1'b1;
        jump_target = 6'd0;
        #2;
        chk("jump_pc1", instr_pc, 1);
        chk("jump_no_done", done, 0);
        next();
        #2;
        chk("jump_pc_back", instr_pc, 0);
        chk("jump_data", instr_data, prog[0]);
        jump_target = 6'd5;
        #2;
        chk("jump_far_done", done, 1);
        next();
        jump_valid  = 1'b0;
        instr_ready = 1'b0;
        #2;
        chk("jump_far_pulse", done, 0);
        chk("jump_far_valid", instr_valid, 0);
        chk("jump_prog_len", prog_len, 3);

        // abort mid-run, then restart from pc 0
        load(16'hB001, 3);
        run_start = 1'b1;
        next();
        run_start   = 1'b0;
        instr_ready = 1'b1;
        next();
        next();
        #2;
        chk("abort_pc2", instr_pc, 2);
        abort       = 1'b1;
        instr_ready = 1'b0;
        next();
        abort = 1'b0;
        #2;
        chk("abort_valid", instr_valid, 0);
        chk("abort_pc", instr_pc, 0);
        chk("abort_prog_len", prog_len, 3);
        chk("abort_done", done, 0);
        run(-1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
